// File: rtl/riscv_trace_buffer_if.sv
// Snoop and read-back bus between riscv_trace_buffer and whoever drives it.
// The master drives the core signals and read requests; the trace buffer is the slave.
interface riscv_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
);
  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = CNT_W + 3*XLEN + 2;

  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    r_out;
  logic [XLEN-1:0]    alu_out;
  logic               mem_read;
  logic               mem_write;
  logic [AW-1:0]      rd_addr;
  logic               rd_en;
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_valid;

  modport master (
    output pc, r_out, alu_out, mem_read, mem_write, rd_addr, rd_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  pc, r_out, alu_out, mem_read, mem_write, rd_addr, rd_en,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture: snoops core signals into a circular buffer with PC trigger,
// qualification mode and sample limit; read back oldest-first through a registered port.
module riscv_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    stop,
  input  logic [1:0]              mode,
  input  logic                    trig_en,
  input  logic [XLEN-1:0]         trig_pc,
  input  logic [CNT_W-1:0]        max_samples,
  riscv_trace_buffer_if.slave     bus,
  output logic [1:0]              state,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    wrapped,
  output logic [CNT_W-1:0]        cycle_cnt
);
  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = CNT_W + 3*XLEN + 2;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      wptr;
  logic [CNT_W-1:0]   sample_cnt, sample_nxt;
  logic [XLEN-1:0]    prev_pc;
  logic               trig_hit, candidate, qualified, do_write;
  logic [AW-1:0]      rd_phys;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] mem [DEPTH];

  assign state = state_q;
  assign entry = {cycle_cnt, bus.pc, bus.r_out, bus.alu_out, bus.mem_read, bus.mem_write};
  // Oldest valid entry sits count slots behind the write pointer.
  assign rd_phys = wptr - count[AW-1:0] + bus.rd_addr;

  // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    candidate  = 1'b0;
    qualified  = 1'b1;
    trig_hit   = !trig_en || (bus.pc == trig_pc);
    sample_nxt = sample_cnt + 1'b1;

    case (state_q)
      ARMED: begin
        if (trig_hit) begin
          candidate = 1'b1;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: candidate = 1'b1;
      default: ;
    endcase

    case (mode)
      2'd1:    qualified = bus.mem_read | bus.mem_write;
      // The trigger cycle always qualifies in change-of-pc mode.
      2'd2:    qualified = (bus.pc != prev_pc) || (state_q == ARMED);
      default: qualified = 1'b1;
    endcase

    do_write = candidate && qualified && !arm && !stop;

    if (do_write && (max_samples != '0) && (sample_nxt == max_samples))
      state_d = DONE;
    if (arm)
      state_d = ARMED;
    if (stop)
      state_d = DONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wptr         <= '0;
      count        <= '0;
      wrapped      <= 1'b0;
      sample_cnt   <= '0;
      prev_pc      <= '0;
      cycle_cnt    <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_cnt    <= cycle_cnt + 1'b1;
      prev_pc      <= bus.pc;
      bus.rd_valid <= bus.rd_en;

      if (bus.rd_en)
        bus.rd_data <= ({1'b0, bus.rd_addr} < count) ? mem[rd_phys] : '0;

      if (arm && !stop) begin
        wptr       <= '0;
        count      <= '0;
        wrapped    <= 1'b0;
        sample_cnt <= '0;
      end else if (do_write) begin
        wptr       <= wptr + 1'b1;
        sample_cnt <= sample_nxt;
        if (count == FULL)
          wrapped <= 1'b1;
        else
          count <= count + 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; count gates which entries are readable.
  always_ff @(posedge clk) begin
    if (do_write)
      mem[wptr] <= entry;
  end
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed self-checking bench for riscv_trace_buffer (XLEN=32, DEPTH=64, CNT_W=16).
module tb_riscv_trace_buffer;
  localparam int XLEN = 32, DEPTH = 64, CNT_W = 16;
  localparam int ENTRY_W = CNT_W + 3*XLEN + 2;

  logic              clk;
  logic              reset;
  logic              arm, stop, trig_en;
  logic [1:0]        mode;
  logic [XLEN-1:0]   trig_pc;
  logic [CNT_W-1:0]  max_samples;
  logic [1:0]        state;
  logic [6:0]        count;
  logic              wrapped;
  logic [CNT_W-1:0]  cycle_cnt;

  int checks = 0;
  int errors = 0;

  riscv_trace_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop), .mode(mode),
    .trig_en(trig_en), .trig_pc(trig_pc), .max_samples(max_samples),
    .bus(bus), .state(state), .count(count), .wrapped(wrapped), .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one core cycle: pc, derived r_out/alu_out, and strobes.
  task automatic drive_core(input logic [31:0] p, input logic mr, input logic mw);
    bus.pc        = p;
    bus.r_out     = p + 32'd1;
    bus.alu_out   = ~p;
    bus.mem_read  = mr;
    bus.mem_write = mw;
  endtask

  task automatic read_entry(input int a, output logic [ENTRY_W-1:0] d);
    bus.rd_addr = 6'(a);
    bus.rd_en   = 1'b1;
    tick();
    bus.rd_en   = 1'b0;
    d = bus.rd_data;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL reset_wrapped got %0d exp 0", wrapped); end
    checks++; if (bus.rd_data !== '0 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd got %0h/%0d exp 0/0", bus.rd_data, bus.rd_valid); end
    #1 reset = 1'b1;
    tick();
    tick();
    checks++; if (cycle_cnt !== 16'd2) begin errors++; $display("FAIL cycle_cnt got %0d exp 2", cycle_cnt); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_hold got %0d exp 0", state); end
  endtask

  task automatic test_limit();
    logic [CNT_W-1:0]   arm_ts;
    logic [ENTRY_W-1:0] e;
    mode = 2'd0; trig_en = 1'b0; max_samples = 16'd40;
    drive_core(32'h0, 1'b0, 1'b0);
    arm_ts = cycle_cnt;
    do_arm();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL limit_armed got %0d exp 1", state); end
    for (int i = 0; i < 40; i++) begin
      drive_core(32'(4*i), 1'b0, 1'b0);
      tick();
      if (i == 20) begin
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL limit_capture got %0d exp 2", state); end
      end
    end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL limit_done got %0d exp 3", state); end
    drive_core(32'h1000, 1'b0, 1'b0);
    tick();
    checks++; if (count !== 7'd40) begin errors++; $display("FAIL limit_count got %0d exp 40", count); end
    checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL limit_wrapped got %0d exp 0", wrapped); end
    read_entry(0, e);
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid got %0d exp 1", bus.rd_valid); end
    checks++; if (e[97:66] !== 32'h0 || e[113:98] !== arm_ts + 16'd1) begin errors++; $display("FAIL limit_first got pc %0h ts %0d exp pc 0 ts %0d", e[97:66], e[113:98], arm_ts + 16'd1); end
    checks++; if (e[65:34] !== 32'h1 || e[33:2] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL limit_data got %0h/%0h exp 1/ffffffff", e[65:34], e[33:2]); end
    read_entry(39, e);
    checks++; if (e[97:66] !== 32'h9C || e[113:98] !== arm_ts + 16'd40) begin errors++; $display("FAIL limit_last got pc %0h ts %0d exp pc 9c ts %0d", e[97:66], e[113:98], arm_ts + 16'd40); end
    read_entry(40, e);
    checks++; if (e !== '0) begin errors++; $display("FAIL limit_past_count got %0h exp 0", e); end
    tick();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop got %0d exp 0", bus.rd_valid); end
  endtask

  task automatic test_trigger();
    logic [ENTRY_W-1:0] e;
    mode = 2'd0; trig_en = 1'b1; trig_pc = 32'h20; max_samples = 16'd3;
    drive_core(32'h0, 1'b0, 1'b0);
    do_arm();
    for (int i = 0; i < 8; i++) begin
      drive_core(32'(4*i), 1'b0, 1'b0);
      tick();
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL trig_wait pc %0h got %0d exp 1", 4*i, state); end
    end
    drive_core(32'h20, 1'b0, 1'b0); tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL trig_fire got %0d exp 2", state); end
    drive_core(32'h24, 1'b0, 1'b0); tick();
    drive_core(32'h28, 1'b0, 1'b0); tick();
    checks++; if (state !== 2'd3 || count !== 7'd3) begin errors++; $display("FAIL trig_done got %0d/%0d exp 3/3", state, count); end
    for (int i = 0; i < 3; i++) begin
      read_entry(i, e);
      checks++; if (e[97:66] !== 32'(32'h20 + 4*i)) begin errors++; $display("FAIL trig_entry%0d got %0h exp %0h", i, e[97:66], 32'h20 + 4*i); end
    end
  endtask

  task automatic test_mode_mem();
    logic [ENTRY_W-1:0] e;
    mode = 2'd1; trig_en = 1'b0; max_samples = 16'd0;
    do_arm();
    for (int i = 0; i < 20; i++) begin
      drive_core(32'(4*i), (4*i == 16), (4*i == 24));
      tick();
    end
    drive_core(32'h0, 1'b0, 1'b0);
    do_stop();
    checks++; if (state !== 2'd3 || count !== 7'd2) begin errors++; $display("FAIL mem_count got %0d/%0d exp 3/2", state, count); end
    read_entry(0, e);
    checks++; if (e[97:66] !== 32'h10 || e[1:0] !== 2'b10) begin errors++; $display("FAIL mem_read_entry got %0h/%b exp 10/10", e[97:66], e[1:0]); end
    read_entry(1, e);
    checks++; if (e[97:66] !== 32'h18 || e[1:0] !== 2'b01) begin errors++; $display("FAIL mem_write_entry got %0h/%b exp 18/01", e[97:66], e[1:0]); end
  endtask

  task automatic test_wrap();
    logic [ENTRY_W-1:0] e;
    mode = 2'd0; trig_en = 1'b0; max_samples = 16'd0;
    do_arm();
    for (int i = 0; i < 100; i++) begin
      drive_core(32'(4*i), 1'b0, 1'b0);
      tick();
    end
    do_stop();
    checks++; if (count !== 7'd64 || wrapped !== 1'b1) begin errors++; $display("FAIL wrap_status got %0d/%0d exp 64/1", count, wrapped); end
    read_entry(0, e);
    checks++; if (e[97:66] !== 32'h90) begin errors++; $display("FAIL wrap_oldest got %0h exp 90", e[97:66]); end
    read_entry(63, e);
    checks++; if (e[97:66] !== 32'h18C) begin errors++; $display("FAIL wrap_newest got %0h exp 18c", e[97:66]); end
  endtask

  task automatic test_mode_pc_change();
    logic [ENTRY_W-1:0] e;
    mode = 2'd2; trig_en = 1'b0; max_samples = 16'd0;
    drive_core(32'h40, 1'b0, 1'b0);
    do_arm();
    for (int i = 0; i < 5; i++) tick();
    drive_core(32'h44, 1'b0, 1'b0);
    tick(); tick(); tick();
    do_stop();
    checks++; if (count !== 7'd2) begin errors++; $display("FAIL pcchg_count got %0d exp 2", count); end
    read_entry(0, e);
    checks++; if (e[97:66] !== 32'h40) begin errors++; $display("FAIL pcchg_first got %0h exp 40", e[97:66]); end
    read_entry(1, e);
    checks++; if (e[97:66] !== 32'h44) begin errors++; $display("FAIL pcchg_second got %0h exp 44", e[97:66]); end
  endtask

  task automatic test_stop_arm_and_reset();
    mode = 2'd0; trig_en = 1'b0; max_samples = 16'd0;
    do_arm();
    for (int i = 0; i < 5; i++) begin
      drive_core(32'(4*i), 1'b0, 1'b0);
      tick();
    end
    checks++; if (state !== 2'd2 || count !== 7'd5) begin errors++; $display("FAIL pre_stop got %0d/%0d exp 2/5", state, count); end
    arm = 1'b1; stop = 1'b1;
    tick();
    arm = 1'b0; stop = 1'b0;
    checks++; if (state !== 2'd3 || count !== 7'd5) begin errors++; $display("FAIL stop_over_arm got %0d/%0d exp 3/5", state, count); end
    do_arm();
    for (int i = 0; i < 3; i++) begin
      drive_core(32'(4*i), 1'b0, 1'b0);
      tick();
    end
    bus.rd_addr = 6'd0; bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++; if (state !== 2'd2 || bus.rd_valid !== 1'b1 || bus.rd_data === '0) begin errors++; $display("FAIL pre_reset got %0d/%0d/%0h exp 2/1/nonzero", state, bus.rd_valid, bus.rd_data); end
    #2 reset = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || count !== 7'd0 || wrapped !== 1'b0 || cycle_cnt !== 16'd0) begin errors++; $display("FAIL async_reset_status got %0d/%0d/%0d/%0d exp 0/0/0/0", state, count, wrapped, cycle_cnt); end
    checks++; if (bus.rd_data !== '0 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL async_reset_rd got %0h/%0d exp 0/0", bus.rd_data, bus.rd_valid); end
    #1 reset = 1'b1;
    tick();
    checks++; if (state !== 2'd0 || count !== 7'd0) begin errors++; $display("FAIL post_reset got %0d/%0d exp 0/0", state, count); end
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; stop = 1'b0; mode = 2'd0; trig_en = 1'b0;
    trig_pc = '0; max_samples = '0;
    bus.rd_addr = '0; bus.rd_en = 1'b0;
    drive_core(32'h0, 1'b0, 1'b0);
    test_reset();
    test_limit();
    test_trigger();
    test_mode_mem();
    test_wrap();
    test_mode_pc_change();
    test_stop_arm_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_trace_buffer.md
Name: riscv_trace_buffer

Overview:
- Synthesizable commit-trace capture block that sits beside riscv_core_with_mem and snoops the core's PC, r_out, ALU result and memory strobes every clock.
- Replaces fixed-length testbench printing with an on-chip, parametrised circular buffer.
- Supports a PC-match trigger, a sample-qualification mode and a sample limit.
- Contents are read back through a registered random-access port addressed oldest-first.

Parameters:
XLEN, 32, width of pc/r_out/alu_out
DEPTH, 64, buffer entries; power of 2, >= 4
CNT_W, 16, width of cycle counter, timestamps and max_samples
ENTRY_W, CNT_W+3*XLEN+2, derived (localparam); packed entry {ts, pc, r_out, alu_out, mem_read, mem_write}, MSB first

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
arm  in  1  pulse: clear buffer and enter ARMED
stop  in  1  pulse: force DONE
mode  in  2  0=every cycle, 1=only cycles with mem_read|mem_write, 2=only cycles where pc differs from previous cycle's pc, 3=same as 0
trig_en  in  1  1: wait for pc==trig_pc before capturing
trig_pc  in  XLEN  trigger address
max_samples  in  CNT_W  stop after this many samples; 0 = unlimited (ring overwrite)
pc  in  XLEN  core PC
r_out  in  XLEN  core result bus
alu_out  in  XLEN  core ALU output
mem_read  in  1  core data-memory read strobe
mem_write  in  1  core data-memory write strobe
rd_addr  in  log2(DEPTH)  read index, 0 = oldest valid entry
rd_en  in  1  read request
rd_data  out  ENTRY_W  read data, valid 1 cycle after rd_en
rd_valid  out  1  registered copy of rd_en
state  out  2  0=IDLE, 1=ARMED, 2=CAPTURE, 3=DONE
count  out  log2(DEPTH)+1  valid entries, saturates at DEPTH
wrapped  out  1  set when an entry has been overwritten
cycle_cnt  out  CNT_W  free-running cycle counter

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; count=0; wrapped=0; cycle_cnt=0; rd_data=0; rd_valid=0.
  - Write pointer=0; internal sample counter=0; prev_pc=0.
  - Memory contents undefined.
  - Reset asserted mid-capture aborts immediately; no partial entry.
- cycle_cnt increments every clock and wraps modulo 2^CNT_W.
- prev_pc updates to pc every clock.
- Precedence each cycle: stop > arm > normal FSM.
- stop in any state -> DONE next cycle; the current cycle is not sampled.
- arm in any state (without stop):
  - Clears count, wrapped, write pointer and sample counter; next state ARMED.
  - Nothing is sampled that cycle.
- IDLE: holds until arm.
- ARMED, trigger condition = !trig_en | (pc==trig_pc):
  - If true this cycle, the cycle is a candidate sample and state -> CAPTURE.
  - Otherwise stay in ARMED.
- CAPTURE: every cycle is a candidate.
- Qualification: a candidate is written only if qualified by mode.
  - Mode 2 compares against prev_pc; the trigger cycle in mode 2 always qualifies.
- Write, on each qualified sample:
  - Entry={cycle_cnt, pc, r_out, alu_out, mem_read, mem_write} written at the write pointer.
  - Pointer increments modulo DEPTH.
  - count increments, saturating at DEPTH.
  - A write when count==DEPTH sets wrapped (sticky until arm/reset).
  - Sample counter increments.
- Limit: when max_samples!=0 and a write makes the sample counter == max_samples, state -> DONE next cycle. That write is stored.
- max_samples > DEPTH is legal: the buffer keeps the newest DEPTH samples and wrapped=1.
- DONE: no writes; holds until arm.
- Read:
  - Physical index = (wptr - count + rd_addr) mod DEPTH.
  - rd_data registered with 1-cycle latency; rd_valid follows rd_en by 1 cycle.
  - rd_addr >= count returns all-zero rd_data.
  - Legal in every state.
  - Read and write in the same cycle to the same physical entry returns the old content.
- The mode input is sampled live every cycle; changing it mid-capture takes effect that cycle.

Test Plan:
- Reset low, then arm, trig_en=0, mode=0, max_samples=40, PC stepping 0,4,8…:
  - DONE after 40 captures; count=40; wrapped=0.
  - rd_addr=0 gives pc=0, ts=arm-cycle+1; rd_addr=39 gives pc=0x9C.
- trig_en=1, trig_pc=0x20, mode=0, max_samples=3: first entry pc=0x20, entries 0x20/0x24/0x28, then DONE; state stays ARMED while pc<0x20.
- mode=1 with mem_read pulsed at pc=0x10 and mem_write at pc=0x18 only, max_samples=0, stop after 20 cycles: count=2; entries carry strobes 10 and 01.
- DEPTH=64, max_samples=0, 100 cycles, PC stepping 0,4,8…: count=64, wrapped=1; rd_addr=0 gives the 37th sample (pc=0x90); rd_addr=63 gives pc=0x18C.
- mode=2 with PC held at 0x40 for 5 cycles (stall), then 0x44: exactly two entries, 0x40 and 0x44.
- arm and stop asserted together in CAPTURE -> DONE, count unchanged. Then reset pulsed low mid-CAPTURE -> all outputs zero, state IDLE, asynchronously before the next clock edge.
